// File: rtl/fadd_prealign_pkg.sv
// Shared types and constants for the single-precision adder front end.
package addpkg;

  localparam int EXP_W     = 8;
  localparam int SIG_W     = 23;
  localparam int BIAS      = 127;
  localparam int MAX_SHIFT = 26;

  // Field view of an IEEE-754 single-precision word.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } fp_fields_t;

  // Same 32 bits seen either as a raw word or as fields.
  typedef union packed {
    logic [EXP_W+SIG_W:0] word;
    fp_fields_t           f;
  } fp_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/fadd_exp_diff.sv
// Effective exponents of both operands and their comparison. Purely combinational.
module fadd_exp_diff #(
  parameter int EXP_W = addpkg::EXP_W
) (
  input  logic [EXP_W-1:0] exp1,
  input  logic [EXP_W-1:0] exp2,
  output logic             n1,
  output logic             n2,
  output logic [EXP_W-1:0] exp1_d,
  output logic [EXP_W-1:0] exp2_d,
  output logic [EXP_W-1:0] exp_r,
  output logic [EXP_W-1:0] diff,
  output logic             borrow
);

  logic [EXP_W:0] sub_ab;

  // Denormals and zero behave as exponent 1 with no hidden bit; then compare.
  always_comb begin
    // NOTE: every output gets a value before any branch so no latch can be inferred.
    n1     = |exp1;
    n2     = |exp2;
    exp1_d = n1 ? exp1 : EXP_W'(1);
    exp2_d = n2 ? exp2 : EXP_W'(1);
    // One extra bit so the top bit is a clean borrow instead of a wrapped value.
    sub_ab = {1'b0, exp1_d} - {1'b0, exp2_d};
    borrow = sub_ab[EXP_W];
    diff   = borrow ? (exp2_d - exp1_d) : sub_ab[EXP_W-1:0];
    exp_r  = borrow ? exp2_d : exp1_d;
  end

endmodule

// File: rtl/fadd_prealign.sv
// Alignment front end of the FP adder: normalises denormals, compares
// exponents, orders the operands by magnitude and decides sign/complement.
// All outputs are registered with one cycle of latency.
module fadd_prealign #(
  parameter int EXP_W     = addpkg::EXP_W,
  parameter int SIG_W     = addpkg::SIG_W,
  parameter int MAX_SHIFT = addpkg::MAX_SHIFT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             opcode,
  input  logic             sign1,
  input  logic [EXP_W-1:0] exp1,
  input  logic [SIG_W-1:0] sig1,
  input  logic             sign2,
  input  logic [EXP_W-1:0] exp2,
  input  logic [SIG_W-1:0] sig2,
  output logic             out_valid,
  output logic [1:0]       n_concat,
  output logic [EXP_W-1:0] exp1_d,
  output logic [EXP_W-1:0] exp2_d,
  output logic [EXP_W-1:0] exp_r,
  output logic [EXP_W-1:0] diff,
  output logic [EXP_W-1:0] shift,
  output logic             borrow,
  output logic             swap,
  output logic [SIG_W:0]   sig_big,
  output logic [SIG_W:0]   sig_small,
  output logic             complement,
  output logic             sign_r
);

  import addpkg::*;

  // Combinational results of the exponent comparator.
  logic             n1_c, n2_c;
  logic [EXP_W-1:0] exp1_c, exp2_c, exp_r_c, diff_c;
  logic             borrow_c;

  // Combinational results of the ordering / sign decision.
  logic [SIG_W:0]   mag1_c, mag2_c;
  logic [EXP_W-1:0] shift_c;
  logic             swap_c, is_sub_c, equal_mag_c, complement_c, sign_r_c;

  // Register next-state and state.
  logic             out_valid_d, out_valid_q;
  logic [1:0]       n_concat_d, n_concat_q;
  logic [EXP_W-1:0] exp1_d_d, exp1_d_q;
  logic [EXP_W-1:0] exp2_d_d, exp2_d_q;
  logic [EXP_W-1:0] exp_r_d, exp_r_q;
  logic [EXP_W-1:0] diff_d, diff_q;
  logic [EXP_W-1:0] shift_d, shift_q;
  logic             borrow_d, borrow_q;
  logic             swap_d, swap_q;
  logic [SIG_W:0]   sig_big_d, sig_big_q;
  logic [SIG_W:0]   sig_small_d, sig_small_q;
  logic             complement_d, complement_q;
  logic             sign_r_d, sign_r_q;

  fadd_exp_diff #(
    .EXP_W (EXP_W)
  ) u_exp_diff (
    .exp1   (exp1),
    .exp2   (exp2),
    .n1     (n1_c),
    .n2     (n2_c),
    .exp1_d (exp1_c),
    .exp2_d (exp2_c),
    .exp_r  (exp_r_c),
    .diff   (diff_c),
    .borrow (borrow_c)
  );

  // Saturate the shift, order operands by magnitude, decide sign and complement.
  always_comb begin
    mag1_c       = {n1_c, sig1};
    mag2_c       = {n2_c, sig2};
    shift_c      = (diff_c > EXP_W'(MAX_SHIFT)) ? EXP_W'(MAX_SHIFT) : diff_c;
    // Equal exponents fall back to the significands; exact ties keep op1 as big.
    swap_c       = borrow_c || ((diff_c == '0) && (mag1_c < mag2_c));
    equal_mag_c  = (diff_c == '0) && (mag1_c == mag2_c);
    is_sub_c     = (op_e'(opcode) == OP_SUB);
    complement_c = sign1 ^ sign2 ^ is_sub_c;
    // The result takes the sign of the larger term; op2's term sign flips on subtract.
    sign_r_c     = swap_c ? (sign2 ^ is_sub_c) : sign1;
    // x - x rounds to +0 under round-to-nearest.
    if (complement_c && equal_mag_c) begin
      sign_r_c = 1'b0;
    end
  end

  // Next state: load the new decision on in_valid, otherwise hold.
  always_comb begin
    out_valid_d  = in_valid;
    n_concat_d   = n_concat_q;
    exp1_d_d     = exp1_d_q;
    exp2_d_d     = exp2_d_q;
    exp_r_d      = exp_r_q;
    diff_d       = diff_q;
    shift_d      = shift_q;
    borrow_d     = borrow_q;
    swap_d       = swap_q;
    sig_big_d    = sig_big_q;
    sig_small_d  = sig_small_q;
    complement_d = complement_q;
    sign_r_d     = sign_r_q;
    if (in_valid) begin
      n_concat_d   = {n1_c, n2_c};
      exp1_d_d     = exp1_c;
      exp2_d_d     = exp2_c;
      exp_r_d      = exp_r_c;
      diff_d       = diff_c;
      shift_d      = shift_c;
      borrow_d     = borrow_c;
      swap_d       = swap_c;
      sig_big_d    = swap_c ? mag2_c : mag1_c;
      sig_small_d  = swap_c ? mag1_c : mag2_c;
      complement_d = complement_c;
      sign_r_d     = sign_r_c;
    end
  end

  // Output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only; it clears every output flop, valid included.
    if (reset) begin
      out_valid_q  <= 1'b0;
      n_concat_q   <= '0;
      exp1_d_q     <= '0;
      exp2_d_q     <= '0;
      exp_r_q      <= '0;
      diff_q       <= '0;
      shift_q      <= '0;
      borrow_q     <= 1'b0;
      swap_q       <= 1'b0;
      sig_big_q    <= '0;
      sig_small_q  <= '0;
      complement_q <= 1'b0;
      sign_r_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the values from before this edge.
      out_valid_q  <= out_valid_d;
      n_concat_q   <= n_concat_d;
      exp1_d_q     <= exp1_d_d;
      exp2_d_q     <= exp2_d_d;
      exp_r_q      <= exp_r_d;
      diff_q       <= diff_d;
      shift_q      <= shift_d;
      borrow_q     <= borrow_d;
      swap_q       <= swap_d;
      sig_big_q    <= sig_big_d;
      sig_small_q  <= sig_small_d;
      complement_q <= complement_d;
      sign_r_q     <= sign_r_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign n_concat   = n_concat_q;
  assign exp1_d     = exp1_d_q;
  assign exp2_d     = exp2_d_q;
  assign exp_r      = exp_r_q;
  assign diff       = diff_q;
  assign shift      = shift_q;
  assign borrow     = borrow_q;
  assign swap       = swap_q;
  assign sig_big    = sig_big_q;
  assign sig_small  = sig_small_q;
  assign complement = complement_q;
  assign sign_r     = sign_r_q;

endmodule

// File: tb/tb_fadd_prealign.sv
// Scoreboard bench for fadd_prealign: stimulus pushes model results into a
// queue, a negedge monitor pops and compares whenever out_valid is seen.
module tb_fadd_prealign;

  import addpkg::*;

  typedef struct packed {
    logic [1:0]  n_concat;
    logic [7:0]  exp1_d;
    logic [7:0]  exp2_d;
    logic [7:0]  exp_r;
    logic [7:0]  diff;
    logic [7:0]  shift;
    logic        borrow;
    logic        swap;
    logic [23:0] sig_big;
    logic [23:0] sig_small;
    logic        complement;
    logic        sign_r;
  } res_t;

  logic        clk = 1'b0;
  logic        reset, in_valid, opcode;
  logic        sign1, sign2;
  logic [7:0]  exp1, exp2;
  logic [22:0] sig1, sig2;
  logic        out_valid;
  logic [1:0]  n_concat;
  logic [7:0]  exp1_d, exp2_d, exp_r, diff, shift;
  logic        borrow, swap, complement, sign_r;
  logic [23:0] sig_big, sig_small;

  int   n_vec  = 0;
  int   n_fail = 0;
  res_t exp_q[$];
  res_t held;
  logic rst_edge = 1'b0;
  logic started  = 1'b0;

  fadd_prealign dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .opcode     (opcode),
    .sign1      (sign1),
    .exp1       (exp1),
    .sig1       (sig1),
    .sign2      (sign2),
    .exp2       (exp2),
    .sig2       (sig2),
    .out_valid  (out_valid),
    .n_concat   (n_concat),
    .exp1_d     (exp1_d),
    .exp2_d     (exp2_d),
    .exp_r      (exp_r),
    .diff       (diff),
    .shift      (shift),
    .borrow     (borrow),
    .swap       (swap),
    .sig_big    (sig_big),
    .sig_small  (sig_small),
    .complement (complement),
    .sign_r     (sign_r)
  );

  always #5 clk = ~clk;

  // Reference: treat each operand as (effective exponent, 24-bit magnitude)
  // and reason about a +/- b directly with integers.
  function automatic res_t model(input logic op, input fp_t a, input fp_t b);
    res_t r;
    int ea, eb, ma, mb, d;
    bit a_bigger, tie, eff_sub, sign_a_term, sign_b_term;
    ea = (a.f.exp == 0) ? 1 : int'(a.f.exp);
    eb = (b.f.exp == 0) ? 1 : int'(b.f.exp);
    ma = ((a.f.exp != 0) ? (1 << 23) : 0) + int'(a.f.sig);
    mb = ((b.f.exp != 0) ? (1 << 23) : 0) + int'(b.f.sig);
    d  = (ea > eb) ? ea - eb : eb - ea;
    a_bigger    = (ea > eb) || (ea == eb && ma >= mb);
    tie         = (ea == eb) && (ma == mb);
    sign_a_term = a.f.sign;
    sign_b_term = b.f.sign ^ op;
    eff_sub     = sign_a_term != sign_b_term;
    r.n_concat   = {a.f.exp != 0, b.f.exp != 0};
    r.exp1_d     = 8'(ea);
    r.exp2_d     = 8'(eb);
    r.exp_r      = 8'((ea > eb) ? ea : eb);
    r.diff       = 8'(d);
    r.shift      = 8'((d > MAX_SHIFT) ? MAX_SHIFT : d);
    r.borrow     = ea < eb;
    r.swap       = !a_bigger;
    r.sig_big    = 24'(a_bigger ? ma : mb);
    r.sig_small  = 24'(a_bigger ? mb : ma);
    r.complement = eff_sub;
    r.sign_r     = (eff_sub && tie) ? 1'b0 : (a_bigger ? sign_a_term : sign_b_term);
    return r;
  endfunction

  // Drive one cycle of inputs; queue the expected result if it will be accepted.
  task automatic apply(input bit rst, input bit vld, input logic op, input fp_t a, input fp_t b);
    reset    = rst;
    in_valid = vld;
    opcode   = op;
    sign1    = a.f.sign;
    exp1     = a.f.exp;
    sig1     = a.f.sig;
    sign2    = b.f.sign;
    exp2     = b.f.exp;
    sig2     = b.f.sig;
    if (vld && !rst) exp_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
  endtask

  function automatic fp_t rand_fp();
    fp_t x;
    int  c;
    x.word = $urandom;
    c = $urandom_range(0, 19);
    if (c < 2)       x.f.exp = 8'd0;
    else if (c == 2) x.f.exp = 8'd255;
    if (c == 3)      x.f.sig = '0;
    return x;
  endfunction

  task automatic apply_random(input bit rst);
    fp_t a, b;
    int  k;
    a = rand_fp();
    b = rand_fp();
    k = $urandom_range(0, 9);
    if (k == 0)      b = a;
    else if (k == 1) b.f.exp = a.f.exp;
    else if (k == 2) b.f.exp = 8'(int'(a.f.exp) + $urandom_range(0, 3));
    apply(rst, $urandom_range(0, 3) != 0, 1'($urandom), a, b);
  endtask

  always @(posedge clk) begin
    rst_edge <= reset;
    started  <= 1'b1;
  end

  // Monitor: reset clears, valid pops the scoreboard, a bubble must hold outputs.
  always @(negedge clk) begin
    res_t act, expv;
    act = '{n_concat, exp1_d, exp2_d, exp_r, diff, shift, borrow, swap,
            sig_big, sig_small, complement, sign_r};
    if (started) begin
      n_vec++;
      if (rst_edge) begin
        if (out_valid !== 1'b0 || act !== '0) begin
          n_fail++;
          $display("FAIL reset_clear: got valid=%b outs=%h, want valid=0 outs=0", out_valid, act);
        end
        held = '0;
      end else if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_valid: got out_valid=1 outs=%h, want no result", act);
        end else begin
          expv = exp_q.pop_front();
          if (act !== expv) begin
            n_fail++;
            $display("FAIL result: got %h, want %h", act, expv);
          end
          held = expv;
        end
      end else if (out_valid === 1'b0) begin
        if (act !== held) begin
          n_fail++;
          $display("FAIL bubble_hold: got %h, want %h", act, held);
        end
      end else begin
        n_fail++;
        $display("FAIL valid_x: got out_valid=%b, want 0 or 1", out_valid);
      end
    end
  end

  initial begin
    fp_t one, p05, p25, v123, v51, v201, p023, p001, zero, v15, v125, inf, tiny;
    one.word  = 32'h3F80_0000;
    p05.word  = 32'h3D4C_CCCD;
    p25.word  = 32'h3E80_0000;
    v123.word = 32'h3F9D_70A4;
    v51.word  = 32'h40A3_3333;
    v201.word = 32'h41A0_CCCD;
    p023.word = 32'h3CBC_6A7F;
    p001.word = 32'h3A83_126F;
    zero.word = 32'h0000_0000;
    v15.word  = 32'h3FC0_0000;
    v125.word = 32'h3FA0_0000;
    inf.word  = 32'h7F80_0000;
    tiny.word = 32'h0000_0001;

    // Reset with random inputs toggling underneath.
    apply_random(1'b1);
    apply_random(1'b1);

    // Directed operand pairs.
    apply(1'b0, 1'b1, OP_ADD, one,  p05);
    apply(1'b0, 1'b1, OP_SUB, p25,  v123);
    apply(1'b0, 1'b1, OP_ADD, p05,  v51);
    apply(1'b0, 1'b1, OP_SUB, zero, p001);
    apply(1'b0, 1'b1, OP_ADD, v201, p023);
    apply(1'b0, 1'b1, OP_SUB, v15,  v15);
    apply(1'b0, 1'b1, OP_SUB, v125, v15);
    apply(1'b0, 1'b1, OP_ADD, inf,  tiny);
    apply(1'b0, 1'b1, OP_SUB, zero, zero);

    // Back-to-back with a bubble, then reset mid-stream.
    apply(1'b0, 1'b1, OP_ADD, one,  v51);
    apply(1'b0, 1'b0, OP_SUB, v123, p25);
    apply(1'b0, 1'b0, OP_ADD, p001, p05);
    apply(1'b0, 1'b1, OP_SUB, v201, v201);
    apply(1'b1, 1'b1, OP_ADD, v15,  one);
    apply(1'b0, 1'b1, OP_SUB, p023, v125);
    apply(1'b0, 1'b0, OP_ADD, one,  one);

    // Random traffic with an occasional reset pulse.
    for (int i = 0; i < 400; i++) begin
      apply_random($urandom_range(0, 49) == 0);
    end

    // Drain and confirm every queued result was seen.
    apply(1'b0, 1'b0, OP_ADD, zero, zero);
    apply(1'b0, 1'b0, OP_ADD, zero, zero);
    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d results outstanding, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/fadd_prealign.md
Name: fadd_prealign

Overview:
Front-end alignment stage of the single-precision FP adder/subtractor. It merges three functions into one registered stage:
- denormal/zero normalisation (denorm_zero function)
- exponent comparison (compare_exponents function)
- operand ordering and result-sign/complement decision (sign_logic function)

Outputs feed the significand shifter and adder stages.

Parameters:
EXP_W, 8, exponent width
SIG_W, 23, stored fraction width (hidden bit excluded)
MAX_SHIFT, 26, saturation limit for alignment shift (24 bits + guard/round/sticky)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  operand pair valid this cycle
opcode  in  1  0 = add, 1 = subtract (op1 - op2)
sign1  in  1  op1 sign
exp1  in  EXP_W  op1 biased exponent
sig1  in  SIG_W  op1 fraction
sign2  in  1  op2 sign
exp2  in  EXP_W  op2 biased exponent
sig2  in  SIG_W  op2 fraction
out_valid  out  1  registered in_valid
n_concat  out  2  hidden bits; [1] = op1, [0] = op2
exp1_d  out  EXP_W  op1 effective exponent
exp2_d  out  EXP_W  op2 effective exponent
exp_r  out  EXP_W  larger effective exponent
diff  out  EXP_W  |exp1_d - exp2_d|
shift  out  EXP_W  min(diff, MAX_SHIFT)
borrow  out  1  exp1_d < exp2_d
swap  out  1  operands exchanged (op2 is larger magnitude)
sig_big  out  SIG_W+1  larger-magnitude significand including hidden bit
sig_small  out  SIG_W+1  smaller-magnitude significand including hidden bit, unshifted
complement  out  1  effective subtraction
sign_r  out  1  result sign

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Timing: all outputs are registered, 1-cycle latency. No backpressure. A new operand pair is accepted every cycle.
- Outputs update only when in_valid = 1. out_valid <= in_valid every cycle.
- Reset: every output register is 0, including out_valid.
- Denorm/zero handling, per operand:
  - If exp == 0: hidden bit = 0 and exp_d = 1.
  - Otherwise: hidden bit = 1 and exp_d = exp.
  - Zero is therefore a denormal with a zero fraction.
- Exponent compare:
  - borrow = exp1_d < exp2_d.
  - diff = borrow ? exp2_d - exp1_d : exp1_d - exp2_d. Computed with an (EXP_W+1)-bit subtract; no wrap.
  - exp_r = max(exp1_d, exp2_d).
  - shift saturates at MAX_SHIFT.
- Swap:
  - swap = borrow OR (diff == 0 AND {n1,sig1} < {n2,sig2}).
  - sig_big and sig_small follow swap.
  - Equal magnitudes give swap = 0.
- Sign logic:
  - complement = sign1 ^ sign2 ^ opcode.
  - sign_r = swap ? (sign2 ^ opcode) : sign1.
  - Exception: if complement = 1 and the magnitudes are exactly equal (same exp_d and same {hidden, fraction}), sign_r = 0 (round-to-nearest +0).
- Infinity and NaN exponents (all ones) are passed through as ordinary values. Special-case handling lives downstream.
- exp = 255 with exp = 0 gives diff = 254, shift = MAX_SHIFT.

Decomposition:
- Shared package (addpkg):
  - EXP_W, SIG_W and BIAS (127) constants.
  - fp_t packed union of the 32-bit word and the {sign, exponent, significand} struct.
  - Add/sub opcode enum.
- One natural combinational sub-module: fadd_exp_diff (effective exponents, diff, borrow, exp_r).
- Swap and sign logic stay inline in the top.
- All registers stay in the top.

Test Plan:
- Scenario 1: reset = 1 for 2 cycles with random inputs -> all outputs 0, out_valid = 0.
- Scenario 2: 1.0 + 0.05 (exp 127 vs 122, sig2 = 0x4CCCCD) -> diff = 5, exp_r = 127, borrow = 0, swap = 0, complement = 0, sign_r = 0, sig_big = 0x800000, sig_small = 0xCCCCCD, one cycle after in_valid.
- Scenario 3: 0.25 - 1.23 (exp 125 vs 127) -> diff = 2, borrow = 1, swap = 1, complement = 1, sign_r = 1. Also 0.05 + 5.1 (122 vs 129) -> diff = 7, swap = 1, complement = 0, sign_r = 0.
- Scenario 4: 0 - 0.001 (exp 0 vs 117) -> exp1_d = 1, n_concat = 2'b01, diff = 116, shift = 26, swap = 1, sign_r = 1. Also 20.1 + 0.023 (131 vs 121) -> diff = 10, swap = 0, sign_r = 0.
- Scenario 5: 1.5 - 1.5 -> diff = 0, swap = 0, complement = 1, sign_r = 0. Also 1.25 - 1.5 (same exponent, sig2 larger) -> swap = 1, sign_r = 1, borrow = 0.
- Scenario 6: back-to-back valid pairs with an in_valid = 0 bubble -> one result per cycle, outputs held and out_valid = 0 during the bubble; reset asserted mid-stream clears the pipeline the next cycle.
